// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem req/ack handshake, one-entry pend buffer, redirect/kill.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirects raise sticky fetch_err and park the FSM.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend;
  logic [31:0] pend_pc;
  logic        err_q;
  logic        redir_bad;
  logic        req_busy;
  logic        consume;
  logic        slot_free;
  logic [31:0] pc_inc;
  logic [31:0] redir_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
  assign fetch_err = err_q;
`else
  assign redir_bad = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
  assign req_busy     = (state == FETCH) || (state == KILL);
  assign imem_req     = req_busy;
  assign consume      = inst_valid && !stall;
  assign slot_free    = !inst_valid || !stall;
  assign pc_inc       = pc + 32'd4;

  assign opcode = inst[6:2];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_pc    <= RESET_PC;
      pend       <= '0;
      pend_pc    <= '0;
      err_q      <= 1'b0;
    end else if (redirect && !err_q) begin
      // An outstanding request keeps its address until acked; the new target waits in pc.
      inst_valid <= 1'b0;
      pend       <= '0;
      pend_pc    <= '0;
      pc         <= redir_target;
      if (redir_bad)
        err_q <= 1'b1;
      if (req_busy && !imem_ack) begin
        state <= KILL;
      end else if (redir_bad) begin
        state <= IDLE;
      end else begin
        state     <= FETCH;
        imem_addr <= redir_target;
      end
    end else begin
      if (consume)
        inst_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!err_q) begin
            state     <= FETCH;
            imem_addr <= pc;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            if (slot_free) begin
              inst       <= imem_rdata;
              inst_pc    <= imem_addr;
              inst_valid <= 1'b1;
            end else begin
              pend    <= imem_rdata;
              pend_pc <= imem_addr;
              state   <= HOLD;
            end
            pc        <= pc_inc;
            imem_addr <= pc_inc;
          end
        end
        HOLD: begin
          // imem_addr already points at pc, so FETCH resumes without a repeat.
          if (!stall) begin
            inst       <= pend;
            inst_pc    <= pend_pc;
            inst_valid <= 1'b1;
            state      <= FETCH;
          end
        end
        KILL: begin
          if (imem_ack) begin
            if (err_q) begin
              state <= IDLE;
            end else begin
              state     <= FETCH;
              imem_addr <= pc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
